// File: rtl/time_set_pkg.sv
// Shared encodings for the alarm-clock mode/edit sequencer.
package time_set_pkg;

  localparam int STATE_W = 3;
  localparam int FIELD_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_CLOCK        = 3'd0,
    ST_SET_TIME     = 3'd1,
    ST_SET_ALARM    = 3'd2,
    ST_COMMIT_TIME  = 3'd3,
    ST_COMMIT_ALARM = 3'd4
  } state_t;

  localparam logic [FIELD_W-1:0] FLD_NONE = 2'd0;
  localparam logic [FIELD_W-1:0] FLD_HOUR = 2'd1;
  localparam logic [FIELD_W-1:0] FLD_MIN  = 2'd2;
  localparam logic [FIELD_W-1:0] FLD_SEC  = 2'd3;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_OK,
    ACT_MODE,
    ACT_SHIFT,
    ACT_UP,
    ACT_DOWN
  } act_t;

  // One action per cycle; coincident up+down with nothing higher cancels out.
  function automatic act_t pick_action(input logic ok, input logic mode, input logic shift,
                                       input logic up, input logic down);
    if (ok) return ACT_OK;
    else if (mode) return ACT_MODE;
    else if (shift) return ACT_SHIFT;
    else if (up && !down) return ACT_UP;
    else if (down && !up) return ACT_DOWN;
    return ACT_NONE;
  endfunction

  function automatic logic [FIELD_W-1:0] next_field(input logic [FIELD_W-1:0] f);
    return (f == FLD_SEC) ? FLD_HOUR : f + 2'd1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detect for one keypad button.
module btn_sync_edge (
  input  logic CLK,
  input  logic RESETN,
  input  logic btn,
  output logic rise
);

  logic meta, sync, prev;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/edit sequencer: buttons -> STATE, edit field, step pulses, commit strobes, idle timeout.
//
// state           | meaning
// ST_CLOCK        | normal display; mode enters edit, ok toggles alarm_en
// ST_SET_TIME     | editing the time of day
// ST_SET_ALARM    | editing the alarm time
// ST_COMMIT_TIME  | one cycle; load_time strobe follows
// ST_COMMIT_ALARM | one cycle; load_alarm strobe follows, alarm armed
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int IDLE_SECONDS = 30
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         sec_tick,
  input  logic         btn_mode,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_shift,
  input  logic         btn_ok,
  output logic [2:0]   STATE,
  output logic [1:0]   field,
  output logic         inc_pulse,
  output logic         dec_pulse,
  output logic         load_time,
  output logic         load_alarm,
  output logic         alarm_en,
  output logic         timeout
);

  localparam int IDLE_W = $clog2(IDLE_SECONDS + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_SECONDS[IDLE_W-1:0];

  logic rise_mode, rise_up, rise_down, rise_shift, rise_ok;

  btn_sync_edge u_mode  (.CLK(CLK), .RESETN(RESETN), .btn(btn_mode),  .rise(rise_mode));
  btn_sync_edge u_up    (.CLK(CLK), .RESETN(RESETN), .btn(btn_up),    .rise(rise_up));
  btn_sync_edge u_down  (.CLK(CLK), .RESETN(RESETN), .btn(btn_down),  .rise(rise_down));
  btn_sync_edge u_shift (.CLK(CLK), .RESETN(RESETN), .btn(btn_shift), .rise(rise_shift));
  btn_sync_edge u_ok    (.CLK(CLK), .RESETN(RESETN), .btn(btn_ok),    .rise(rise_ok));

  state_t              state_q, state_d;
  logic [FIELD_W-1:0]  field_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                alarm_en_d, inc_d, dec_d, load_time_d, load_alarm_d, timeout_d;
  logic                accepted, in_set;
  act_t                act;

  assign STATE  = state_q;
  assign in_set = (state_q == ST_SET_TIME) || (state_q == ST_SET_ALARM);

  always_comb begin
    act          = pick_action(rise_ok, rise_mode, rise_shift, rise_up, rise_down);
    state_d      = state_q;
    field_d      = field;
    alarm_en_d   = alarm_en;
    inc_d        = 1'b0;
    dec_d        = 1'b0;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    timeout_d    = 1'b0;
    accepted     = 1'b0;

    case (state_q)
      ST_CLOCK: begin
        field_d = FLD_NONE;
        if (act == ACT_MODE) begin
          state_d  = ST_SET_TIME;
          field_d  = FLD_HOUR;
          accepted = 1'b1;
        end else if (act == ACT_OK) begin
          alarm_en_d = ~alarm_en;
          accepted   = 1'b1;
        end
      end
      ST_SET_TIME, ST_SET_ALARM: begin
        accepted = (act != ACT_NONE);
        case (act)
          ACT_OK: begin
            if (state_q == ST_SET_TIME) state_d = ST_COMMIT_TIME;
            else state_d = ST_COMMIT_ALARM;
            field_d = FLD_NONE;
          end
          ACT_MODE: begin
            if (state_q == ST_SET_TIME) begin
              state_d = ST_SET_ALARM;
              field_d = FLD_HOUR;
            end else begin
              state_d = ST_CLOCK;
              field_d = FLD_NONE;
            end
          end
          ACT_SHIFT: field_d = next_field(field);
          ACT_UP:    inc_d = 1'b1;
          ACT_DOWN:  dec_d = 1'b1;
          ACT_NONE: begin
            // a button action in the same cycle always beats the timeout
            if (idle_q == IDLE_MAX) begin
              state_d   = ST_CLOCK;
              field_d   = FLD_NONE;
              timeout_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_COMMIT_TIME: begin
        load_time_d = 1'b1;
        state_d     = ST_CLOCK;
        field_d     = FLD_NONE;
      end
      ST_COMMIT_ALARM: begin
        load_alarm_d = 1'b1;
        alarm_en_d   = 1'b1;
        state_d      = ST_CLOCK;
        field_d      = FLD_NONE;
      end
      default: begin
        state_d = ST_CLOCK;
        field_d = FLD_NONE;
      end
    endcase

    if (accepted || (state_d != state_q)) idle_d = '0;
    else if (sec_tick && in_set && (idle_q != IDLE_MAX)) idle_d = idle_q + IDLE_W'(1);
    else idle_d = idle_q;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_CLOCK;
      field      <= FLD_NONE;
      idle_q     <= '0;
      alarm_en   <= 1'b0;
      inc_pulse  <= 1'b0;
      dec_pulse  <= 1'b0;
      load_time  <= 1'b0;
      load_alarm <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      field      <= field_d;
      idle_q     <= idle_d;
      alarm_en   <= alarm_en_d;
      inc_pulse  <= inc_d;
      dec_pulse  <= dec_d;
      load_time  <= load_time_d;
      load_alarm <= load_alarm_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected output snapshots queued per target cycle.
module tb_time_set_ctrl;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       sec_tick;
  logic       btn_mode, btn_up, btn_down, btn_shift, btn_ok;
  logic [2:0] STATE;
  logic [1:0] field;
  logic       inc_pulse, dec_pulse, load_time, load_alarm, alarm_en, timeout;

  time_set_ctrl #(.IDLE_SECONDS(3)) dut (
    .CLK(CLK), .RESETN(RESETN), .sec_tick(sec_tick),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_shift(btn_shift), .btn_ok(btn_ok),
    .STATE(STATE), .field(field), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .load_time(load_time), .load_alarm(load_alarm), .alarm_en(alarm_en), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  // {STATE, field, inc, dec, load_time, load_alarm, alarm_en, timeout}
  logic [10:0] obs;
  assign obs = {STATE, field, inc_pulse, dec_pulse, load_time, load_alarm, alarm_en, timeout};

  typedef struct {
    int          cyc;
    string       tag;
    logic [10:0] vec;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic e_aen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, 32'(obs), 32'(e.vec));
    end
  end

  function automatic logic [10:0] ev(input int st, input int f, input bit inc, input bit dec,
                                     input bit lt, input bit la, input bit aen, input bit to);
    logic [2:0] s3;
    logic [1:0] f2;
    s3 = 3'(st);
    f2 = 2'(f);
    return {s3, f2, inc, dec, lt, la, aen, to};
  endfunction

  task automatic exp_at(input int k, input string tag, input logic [10:0] v);
    sb.push_back('{cyc + k, tag, v});
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic [4:0] m);
    {btn_ok, btn_mode, btn_shift, btn_up, btn_down} = m;
  endtask

  // mask = {ok, mode, shift, up, down}; snapshots at E1, E2, E2+1, E2+2
  task automatic press(input logic [4:0] m, input string tag, input logic [10:0] v_pre,
                       input logic [10:0] v_post, input logic [10:0] v_next, input logic [10:0] v_last);
    exp_at(2, {tag, "_pre"}, v_pre);
    exp_at(3, tag, v_post);
    exp_at(4, {tag, "_next"}, v_next);
    exp_at(5, {tag, "_last"}, v_last);
    drive(m);
    wait_n(5);
    drive(5'b0);
    wait_n(3);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    wait_n(1);
    sec_tick = 1'b0;
  endtask

  localparam logic [4:0] B_OK = 5'b10000, B_MODE = 5'b01000, B_SHIFT = 5'b00100,
                         B_UP = 5'b00010, B_DOWN = 5'b00001;

  task automatic enter_set_time();
    press(B_MODE, "to_set_time", ev(0,0,0,0,0,0,e_aen,0), ev(1,1,0,0,0,0,e_aen,0),
          ev(1,1,0,0,0,0,e_aen,0), ev(1,1,0,0,0,0,e_aen,0));
  endtask

  task automatic enter_set_alarm();
    enter_set_time();
    press(B_MODE, "to_set_alarm", ev(1,1,0,0,0,0,e_aen,0), ev(2,1,0,0,0,0,e_aen,0),
          ev(2,1,0,0,0,0,e_aen,0), ev(2,1,0,0,0,0,e_aen,0));
  endtask

  initial begin
    int fseq [4];
    int fcur;
    fseq[0] = 2; fseq[1] = 3; fseq[2] = 1; fseq[3] = 2;
    RESETN = 1'b0;
    sec_tick = 1'b0;
    drive(5'b0);
    wait_n(3);
    chk("reset", 32'(obs), 32'(0));
    RESETN = 1'b1;
    wait_n(3);

    // ok in CLOCK toggles alarm_en 0 -> 1 -> 0
    press(B_OK, "clk_ok1", ev(0,0,0,0,0,0,0,0), ev(0,0,0,0,0,0,1,0),
          ev(0,0,0,0,0,0,1,0), ev(0,0,0,0,0,0,1,0));
    press(B_OK, "clk_ok2", ev(0,0,0,0,0,0,1,0), ev(0,0,0,0,0,0,0,0),
          ev(0,0,0,0,0,0,0,0), ev(0,0,0,0,0,0,0,0));

    // up/down/shift ignored in CLOCK
    press(B_UP | B_SHIFT, "clk_ign", ev(0,0,0,0,0,0,0,0), ev(0,0,0,0,0,0,0,0),
          ev(0,0,0,0,0,0,0,0), ev(0,0,0,0,0,0,0,0));

    // held mode acts exactly once
    exp_at(2, "hold_pre", ev(0,0,0,0,0,0,0,0));
    exp_at(3, "hold_e2", ev(1,1,0,0,0,0,0,0));
    exp_at(10, "hold_end", ev(1,1,0,0,0,0,0,0));
    drive(B_MODE);
    wait_n(10);
    drive(5'b0);
    wait_n(3);

    // shift cycles field 1->2->3->1->2
    fcur = 1;
    for (int i = 0; i < 4; i++) begin
      press(B_SHIFT, $sformatf("shift%0d", i), ev(1,fcur,0,0,0,0,0,0), ev(1,fseq[i],0,0,0,0,0,0),
            ev(1,fseq[i],0,0,0,0,0,0), ev(1,fseq[i],0,0,0,0,0,0));
      fcur = fseq[i];
    end

    press(B_UP, "up", ev(1,2,0,0,0,0,0,0), ev(1,2,1,0,0,0,0,0),
          ev(1,2,0,0,0,0,0,0), ev(1,2,0,0,0,0,0,0));
    press(B_DOWN, "down", ev(1,2,0,0,0,0,0,0), ev(1,2,0,1,0,0,0,0),
          ev(1,2,0,0,0,0,0,0), ev(1,2,0,0,0,0,0,0));
    press(B_UP | B_DOWN, "updown", ev(1,2,0,0,0,0,0,0), ev(1,2,0,0,0,0,0,0),
          ev(1,2,0,0,0,0,0,0), ev(1,2,0,0,0,0,0,0));

    // ok in SET_TIME: STATE 3 one cycle, then load_time with STATE 0
    press(B_OK, "commit_t", ev(1,2,0,0,0,0,0,0), ev(3,0,0,0,0,0,0,0),
          ev(0,0,0,0,1,0,0,0), ev(0,0,0,0,0,0,0,0));

    // field reset on SET_ALARM entry, then ok commits alarm
    enter_set_time();
    press(B_SHIFT, "pre_alarm_shift", ev(1,1,0,0,0,0,0,0), ev(1,2,0,0,0,0,0,0),
          ev(1,2,0,0,0,0,0,0), ev(1,2,0,0,0,0,0,0));
    press(B_MODE, "to_alarm_f1", ev(1,2,0,0,0,0,0,0), ev(2,1,0,0,0,0,0,0),
          ev(2,1,0,0,0,0,0,0), ev(2,1,0,0,0,0,0,0));
    press(B_OK, "commit_a", ev(2,1,0,0,0,0,0,0), ev(4,0,0,0,0,0,0,0),
          ev(0,0,0,0,0,1,1,0), ev(0,0,0,0,0,0,1,0));
    e_aen = 1'b1;

    // ok+mode together in SET_TIME commits
    enter_set_time();
    press(B_OK | B_MODE, "okmode", ev(1,1,0,0,0,0,1,0), ev(3,0,0,0,0,0,1,0),
          ev(0,0,0,0,1,0,1,0), ev(0,0,0,0,0,0,1,0));

    // mode from SET_ALARM exits without commit
    enter_set_alarm();
    press(B_MODE, "alarm_exit", ev(2,1,0,0,0,0,1,0), ev(0,0,0,0,0,0,1,0),
          ev(0,0,0,0,0,0,1,0), ev(0,0,0,0,0,0,1,0));

    // idle timeout after 3 ticks in SET_ALARM
    enter_set_alarm();
    tick();
    tick();
    exp_at(1, "to_t3", ev(2,1,0,0,0,0,1,0));
    tick();
    exp_at(1, "to_hit", ev(0,0,0,0,0,0,1,1));
    exp_at(2, "to_end", ev(0,0,0,0,0,0,1,0));
    wait_n(3);

    // up before third tick restarts the 3-tick window
    enter_set_alarm();
    tick();
    tick();
    press(B_UP, "rearm_up", ev(2,1,0,0,0,0,1,0), ev(2,1,1,0,0,0,1,0),
          ev(2,1,0,0,0,0,1,0), ev(2,1,0,0,0,0,1,0));
    tick();
    tick();
    exp_at(1, "rearm_t3", ev(2,1,0,0,0,0,1,0));
    tick();
    exp_at(1, "rearm_to", ev(0,0,0,0,0,0,1,1));
    exp_at(2, "rearm_end", ev(0,0,0,0,0,0,1,0));
    wait_n(3);

    // async reset mid-edit with ok in flight: all clear, no commit afterwards
    enter_set_time();
    drive(B_OK);
    wait_n(2);
    #2 RESETN = 1'b0;
    #1 chk("rst_async", 32'(obs), 32'(0));
    drive(5'b0);
    wait_n(3);
    RESETN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_n(1);
      chk($sformatf("rst_after%0d", i), 32'(obs), 32'(0));
    end

    wait_n(2);
    chk("sb_drain", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
